// File: rtl/pd_rx_byte_buffer.sv
// Byte-granular circular buffer feeding the packet parser a 64-byte look-ahead window.
// Optional almost_full output is built only when PD_BUF_ALMOST_FULL_EN is defined.
module pd_rx_byte_buffer #(
    parameter int DEPTH     = 256,
    parameter int AF_THRESH = 192
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     w,
    input  logic [63:0]              valid,
    input  logic [511:0]             wr_data,
    input  logic                     flush,
    input  logic                     rd_en,
    input  logic [6:0]               rd_num,
    output logic [511:0]             rd_data,
    output logic [6:0]               rd_avail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
`ifdef PD_BUF_ALMOST_FULL_EN
    ,
    output logic                     almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [6:0]    r_rd_avail;
    logic          r_overflow;
    logic          r_underflow;

    logic [6:0]    w_wr_num;
    logic          w_run;
    logic [CW-1:0] w_free;
    logic [CW-1:0] w_wr_ext;
    logic [CW-1:0] w_rd_ext;
    logic          w_wr_ok;
    logic          w_wr_drop;
    logic          w_rd_legal;
    logic          w_rd_ok;
    logic          w_rd_bad;
    logic [CW-1:0] w_count_next;
    logic [6:0]    w_avail_next;

    // Write length is the run of ones in the mask starting at byte 0
    always_comb begin
        w_wr_num = 7'd0;
        w_run    = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (w_run && valid[i]) begin
                w_wr_num = w_wr_num + 7'd1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // Admission uses the pre-read occupancy, so a same-cycle read never frees space
    always_comb begin
        w_free     = CW'(DEPTH) - r_count;
        w_wr_ext   = CW'(w_wr_num);
        w_rd_ext   = CW'(rd_num);
        w_wr_ok    = w && (w_wr_num != 7'd0) && (w_wr_ext <= w_free);
        w_wr_drop  = w && (w_wr_num != 7'd0) && !(w_wr_ext <= w_free);
        w_rd_legal = (rd_num <= 7'd64) && (w_rd_ext <= r_count);
        w_rd_ok    = rd_en && w_rd_legal;
        w_rd_bad   = rd_en && !w_rd_legal;
        w_count_next = r_count
                     + (w_wr_ok ? w_wr_ext : {CW{1'b0}})
                     - (w_rd_ok ? w_rd_ext : {CW{1'b0}});
        if (w_count_next > CW'(7'd64)) begin
            w_avail_next = 7'd64;
        end else begin
            w_avail_next = w_count_next[6:0];
        end
    end

    // Pointer, occupancy and status registers; flush acts as a synchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_rd_avail  <= 7'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_rd_avail  <= 7'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ok ? (r_wr_ptr + AW'(w_wr_num)) : r_wr_ptr;
            r_rd_ptr    <= w_rd_ok ? (r_rd_ptr + AW'(rd_num)) : r_rd_ptr;
            r_count     <= w_count_next;
            r_rd_avail  <= w_avail_next;
            r_overflow  <= r_overflow | w_wr_drop;
            r_underflow <= w_rd_bad;
        end
    end

    // Byte storage; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clk) begin
        if (w_wr_ok && !flush) begin
            for (int i = 0; i < 64; i++) begin
                if (7'(i) < w_wr_num) begin
                    r_mem[r_wr_ptr + AW'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Look-ahead window, zero beyond the current occupancy
    always_comb begin
        rd_data = {512{1'b0}};
        for (int i = 0; i < 64; i++) begin
            if (CW'(i) < r_count) begin
                rd_data[8*i +: 8] = r_mem[r_rd_ptr + AW'(i)];
            end else begin
                rd_data[8*i +: 8] = 8'd0;
            end
        end
    end

    assign rd_avail  = r_rd_avail;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef PD_BUF_ALMOST_FULL_EN
    logic r_almost_full;

    // Threshold flag tracks the occupancy being loaded this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_almost_full <= 1'b0;
        end else if (flush) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_next >= CW'(AF_THRESH));
        end
    end

    assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_pd_rx_byte_buffer.sv
// Scoreboard bench for pd_rx_byte_buffer: each stimulus cycle queues its expected state,
// a negedge monitor pops and compares.
module tb_pd_rx_byte_buffer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         w = 1'b0;
    logic [63:0]  valid = 64'h0;
    logic [511:0] wr_data = 512'h0;
    logic         flush = 1'b0;
    logic         rd_en = 1'b0;
    logic [6:0]   rd_num = 7'd0;
    logic [511:0] rd_data;
    logic [6:0]   rd_avail;
    logic [8:0]   count;
    logic         overflow;
    logic         underflow;
`ifdef PD_BUF_ALMOST_FULL_EN
    logic         almost_full;
`endif

    pd_rx_byte_buffer #(.DEPTH(256), .AF_THRESH(192)) dut (
        .clk(clk), .reset_n(reset_n), .w(w), .valid(valid), .wr_data(wr_data),
        .flush(flush), .rd_en(rd_en), .rd_num(rd_num), .rd_data(rd_data),
        .rd_avail(rd_avail), .count(count), .overflow(overflow), .underflow(underflow)
`ifdef PD_BUF_ALMOST_FULL_EN
        , .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [8:0]   cnt;
        logic [6:0]   avail;
        logic         ovf;
        logic         unf;
        logic         af;
        logic         chk;
        logic [511:0] data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0]  ALL   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]  M58   = 64'h03FF_FFFF_FFFF_FFFF;
    localparam logic [63:0]  M52   = 64'h000F_FFFF_FFFF_FFFF;
    localparam logic [511:0] FILLD = {64{8'h5A}};
    localparam logic [511:0] NONE  = 512'h0;
    localparam logic [127:0] W16   = 128'h0F0E0D0C0B0A09080706050403020100;

    task automatic cmp(input string nm, input string fld, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expected record per observed cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            cmp(mon_e.name, "count", 512'(count), 512'(mon_e.cnt));
            cmp(mon_e.name, "rd_avail", 512'(rd_avail), 512'(mon_e.avail));
            cmp(mon_e.name, "overflow", 512'(overflow), 512'(mon_e.ovf));
            cmp(mon_e.name, "underflow", 512'(underflow), 512'(mon_e.unf));
`ifdef PD_BUF_ALMOST_FULL_EN
            cmp(mon_e.name, "almost_full", 512'(almost_full), 512'(mon_e.af));
`endif
            if (mon_e.chk) begin
                cmp(mon_e.name, "rd_data", rd_data, mon_e.data);
            end
        end
    end

    task automatic step(input string nm, input logic iw, input logic [63:0] iv, input logic [511:0] id,
                        input logic ird, input logic [6:0] irn, input logic ifl,
                        input logic [8:0] ecnt, input logic eovf, input logic eunf,
                        input logic echk, input logic [511:0] edata);
        exp_t e;
        w = iw; valid = iv; wr_data = id; rd_en = ird; rd_num = irn; flush = ifl;
        @(posedge clk);
        #1;
        e.name  = nm;
        e.cnt   = ecnt;
        e.avail = (ecnt > 9'd64) ? 7'd64 : ecnt[6:0];
        e.ovf   = eovf;
        e.unf   = eunf;
        e.af    = (ecnt >= 9'd192);
        e.chk   = echk;
        e.data  = edata;
        q.push_back(e);
        w = 1'b0; valid = 64'h0; rd_en = 1'b0; rd_num = 7'd0; flush = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [63:0] iv, input logic [511:0] id,
                      input logic [8:0] ecnt, input logic eovf, input logic echk, input logic [511:0] edata);
        step(nm, 1'b1, iv, id, 1'b0, 7'd0, 1'b0, ecnt, eovf, 1'b0, echk, edata);
    endtask

    task automatic rd(input string nm, input logic [6:0] n, input logic [8:0] ecnt, input logic eovf,
                      input logic eunf, input logic echk, input logic [511:0] edata);
        step(nm, 1'b0, 64'h0, NONE, 1'b1, n, 1'b0, ecnt, eovf, eunf, echk, edata);
    endtask

    task automatic idle(input string nm, input logic [8:0] ecnt, input logic eovf,
                        input logic echk, input logic [511:0] edata);
        step(nm, 1'b0, 64'h0, NONE, 1'b0, 7'd0, 1'b0, ecnt, eovf, 1'b0, echk, edata);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle("reset", 9'd0, 1'b0, 1'b1, NONE);

        wr("gen1x4", 64'h0F, {448'h0, 64'h9988776644332211}, 9'd4, 1'b0, 1'b1, {480'h0, 32'h44332211});
        rd("drain4", 7'd4, 9'd0, 1'b0, 1'b0, 1'b1, NONE);

        wr("fill_a", ALL, FILLD, 9'd64, 1'b0, 1'b0, NONE);
        wr("fill_b", ALL, FILLD, 9'd128, 1'b0, 1'b0, NONE);
        wr("fill_c", ALL, FILLD, 9'd192, 1'b0, 1'b1, FILLD);
        wr("fill_d", M58, FILLD, 9'd250, 1'b0, 1'b0, NONE);
        rd("cons_a", 7'd64, 9'd186, 1'b0, 1'b0, 1'b0, NONE);
        rd("cons_b", 7'd64, 9'd122, 1'b0, 1'b0, 1'b0, NONE);
        rd("cons_c", 7'd64, 9'd58, 1'b0, 1'b0, 1'b0, NONE);
        rd("cons_d", 7'd58, 9'd0, 1'b0, 1'b0, 1'b1, NONE);
        wr("wrap16", 64'hFFFF, {{384{1'b1}}, W16}, 9'd16, 1'b0, 1'b1, {384'h0, W16});

        rd("rd6", 7'd6, 9'd10, 1'b0, 1'b0, 1'b1, {432'h0, 80'h0F0E0D0C0B0A09080706});
        step("simul", 1'b1, 64'hFF, {448'h0, 64'hA7A6A5A4A3A2A1A0}, 1'b1, 7'd6, 1'b0,
             9'd12, 1'b0, 1'b0, 1'b1, {416'h0, 96'hA7A6A5A4A3A2A1A0_0F0E0D0C});
        rd("rd9", 7'd9, 9'd3, 1'b0, 1'b0, 1'b1, {488'h0, 24'hA7A6A5});
        rd("underflow", 7'd5, 9'd3, 1'b0, 1'b1, 1'b1, {488'h0, 24'hA7A6A5});
        idle("unf_clear", 9'd3, 1'b0, 1'b1, {488'h0, 24'hA7A6A5});
        rd("rd0", 7'd0, 9'd3, 1'b0, 1'b0, 1'b1, {488'h0, 24'hA7A6A5});
        wr("w_nomask", 64'h0, FILLD, 9'd3, 1'b0, 1'b1, {488'h0, 24'hA7A6A5});
        wr("w_bit0_clr", 64'hFFFF_FFFF_FFFF_FFFE, FILLD, 9'd3, 1'b0, 1'b1, {488'h0, 24'hA7A6A5});
        wr("mask_gap", 64'hF7, {448'h0, 64'h8877665544332211}, 9'd6, 1'b0, 1'b1, {464'h0, 48'h332211A7A6A5});

        wr("ofill_a", ALL, FILLD, 9'd70, 1'b0, 1'b0, NONE);
        wr("ofill_b", ALL, FILLD, 9'd134, 1'b0, 1'b0, NONE);
        wr("ofill_c", ALL, FILLD, 9'd198, 1'b0, 1'b0, NONE);
        wr("ofill_d", M52, FILLD, 9'd250, 1'b0, 1'b0, NONE);
        wr("overflow", 64'hFF, FILLD, 9'd250, 1'b1, 1'b0, NONE);
        idle("ovf_sticky", 9'd250, 1'b1, 1'b0, NONE);
        rd("rd65", 7'd65, 9'd250, 1'b1, 1'b1, 1'b0, NONE);
        wr("exact_fill", 64'h3F, FILLD, 9'd256, 1'b1, 1'b0, NONE);
        wr("full_drop", 64'h01, FILLD, 9'd256, 1'b1, 1'b0, NONE);

        step("flush", 1'b1, ALL, FILLD, 1'b1, 7'd10, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1, NONE);
        idle("post_flush", 9'd0, 1'b0, 1'b1, NONE);
        wr("after_flush", 64'h0F, {480'h0, 32'hDDCCBBAA}, 9'd4, 1'b0, 1'b1, {480'h0, 32'hDDCCBBAA});

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
